// File: rtl/occf_wb_sink.sv
// ---------------------------------------------------------------------------
// occf_wb_sink
//
// OCC fabric sink. A Wishbone pipelined (B4) write-only slave that receives a
// 128-bit packet stream (one packet = one CYC assertion), buffers each word
// together with SOF/EOF framing in a small FIFO, and replays it on a simple
// dreq/dvalid port towards the OCC packet-processing logic.
//
// FIFO entry layout: {sof, eof, adr[3:0], sel[15:0], dat[127:0]} = 150 bits.
// An entry with eof=1 is a packet-end marker and carries no data.
//
// Parameters
//   g_FIFO_DEPTH          FIFO entries, power of 2, >= 4
//   g_WITH_FIFO_INFERRED  1: register-array storage (reset-cleared)
//                         0: RAM-style storage (no reset on the array)
//                         Cycle behaviour is identical for both.
//
// Compile-time option
//   OCCF_SINK_ERR_EN      when defined, a non-stalled strobe with we=0 gives a
//                         one-cycle snk_err_o pulse instead of an ack. When not
//                         defined, snk_err_o is tied low and such strobes are
//                         silently dropped.
//
// Ports
//   clk_i, rst_n_i        clock; asynchronous reset, active HIGH despite name
//   snk_*                 Wishbone B4 pipelined slave (write data in,
//                         stall/ack/err/rty out; rty is always 0)
//   addr_o, data_o,
//   bytesel_o, dvalid_o   popped word, valid for one cycle per word
//   sof_o                 high with the first word of a packet
//   eof_o                 packet-end pulse, dvalid_o is low in that cycle
//   dreq_i                consumer ready; at most one FIFO pop per cycle
//
// Handshake: a WB word is taken on a clock edge where cyc & stb & we & ~stall;
// snk_ack_o follows one cycle later. On the output side a pop happens on an
// edge where dreq_i & ~empty, and the popped entry is presented the following
// cycle; every output is 0 in cycles that do not follow a pop.
// ---------------------------------------------------------------------------
module occf_wb_sink #(
    parameter int g_FIFO_DEPTH         = 8,
    parameter bit g_WITH_FIFO_INFERRED = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [127:0] snk_dat_i,
    input  logic [3:0]   snk_adr_i,
    input  logic [15:0]  snk_sel_i,
    input  logic         snk_cyc_i,
    input  logic         snk_stb_i,
    input  logic         snk_we_i,
    output logic         snk_stall_o,
    output logic         snk_ack_o,
    output logic         snk_err_o,
    output logic         snk_rty_o,
    output logic [3:0]   addr_o,
    output logic [127:0] data_o,
    output logic         dvalid_o,
    output logic         sof_o,
    output logic         eof_o,
    output logic [15:0]  bytesel_o,
    input  logic         dreq_i
);

    localparam int AW = $clog2(g_FIFO_DEPTH);
    localparam int EW = 150;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]   fill;
    logic [EW-1:0] mem_q [g_FIFO_DEPTH];

    logic          cyc_q, cyc_d;
    logic          sof_pend_q, sof_pend_d;
    logic          got_word_q, got_word_d;
    logic          ack_q, ack_d;

    logic          dvalid_q, dvalid_d;
    logic          sof_q, sof_d;
    logic          eof_q, eof_d;
    logic [3:0]    addr_q, addr_d;
    logic [15:0]   sel_q, sel_d;
    logic [127:0]  data_q, data_d;

    logic          stall;
    logic          accept;
    logic          cyc_fall;
    logic          eof_push;
    logic          push;
    logic          empty;
    logic          pop;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] rd_entry;

    always_comb begin
        fill     = wr_ptr_q - rd_ptr_q;
        // One slot is always held back so the EOF marker can never be refused.
        stall    = (fill >= (AW+1)'(g_FIFO_DEPTH - 1));
        accept   = snk_cyc_i & snk_stb_i & snk_we_i & ~stall;
        cyc_fall = cyc_q & ~snk_cyc_i;
        // Empty cycles (no word accepted) leave no trace in the FIFO.
        eof_push = cyc_fall & got_word_q;
        // accept needs cyc high and eof_push needs cyc low: never both.
        push     = accept | eof_push;
        empty    = (fill == '0);
        pop      = dreq_i & ~empty;
        rd_entry = mem_q[rd_ptr_q[AW-1:0]];

        if (accept) begin
            wr_entry = {sof_pend_q, 1'b0, snk_adr_i, snk_sel_i, snk_dat_i};
        end else begin
            wr_entry = {1'b0, 1'b1, 148'd0};
        end

        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cyc_d      = snk_cyc_i;
        ack_d      = accept;

        sof_pend_d = sof_pend_q;
        if (accept) begin
            sof_pend_d = 1'b0;
        end else if (cyc_fall) begin
            sof_pend_d = 1'b1;
        end

        got_word_d = got_word_q;
        if (cyc_fall) begin
            got_word_d = 1'b0;
        end else if (accept) begin
            got_word_d = 1'b1;
        end

        // Output stage: zero unless something was popped this cycle.
        dvalid_d = 1'b0;
        sof_d    = 1'b0;
        eof_d    = 1'b0;
        addr_d   = '0;
        sel_d    = '0;
        data_d   = '0;
        if (pop) begin
            if (rd_entry[148]) begin
                eof_d = 1'b1;
            end else begin
                dvalid_d = 1'b1;
                sof_d    = rd_entry[149];
                addr_d   = rd_entry[147:144];
                sel_d    = rd_entry[143:128];
                data_d   = rd_entry[127:0];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_n_i) begin
        if (rst_n_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cyc_q      <= 1'b0;
            sof_pend_q <= 1'b1;
            got_word_q <= 1'b0;
            ack_q      <= 1'b0;
            dvalid_q   <= 1'b0;
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
            addr_q     <= '0;
            sel_q      <= '0;
            data_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cyc_q      <= cyc_d;
            sof_pend_q <= sof_pend_d;
            got_word_q <= got_word_d;
            ack_q      <= ack_d;
            dvalid_q   <= dvalid_d;
            sof_q      <= sof_d;
            eof_q      <= eof_d;
            addr_q     <= addr_d;
            sel_q      <= sel_d;
            data_q     <= data_d;
        end
    end

    // Storage. Pointers alone define occupancy, so the RAM-style variant does
    // not need its contents cleared on reset.
    generate
        if (g_WITH_FIFO_INFERRED) begin : g_regs
            always_ff @(posedge clk_i or posedge rst_n_i) begin
                if (rst_n_i) begin
                    for (int i = 0; i < g_FIFO_DEPTH; i++) begin
                        mem_q[i] <= '0;
                    end
                end else if (push) begin
                    mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
                end
            end
        end else begin : g_ram
            always_ff @(posedge clk_i) begin
                if (push) begin
                    mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
                end
            end
        end
    endgenerate

`ifdef OCCF_SINK_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = snk_cyc_i & snk_stb_i & ~snk_we_i & ~stall;
    end

    always_ff @(posedge clk_i or posedge rst_n_i) begin
        if (rst_n_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign snk_err_o = err_q;
`else
    assign snk_err_o = 1'b0;
`endif

    assign snk_stall_o = stall;
    assign snk_ack_o   = ack_q;
    assign snk_rty_o   = 1'b0;
    assign dvalid_o    = dvalid_q;
    assign sof_o       = sof_q;
    assign eof_o       = eof_q;
    assign addr_o      = addr_q;
    assign bytesel_o   = sel_q;
    assign data_o      = data_q;

endmodule

// File: tb/tb_occf_wb_sink.sv
// ---------------------------------------------------------------------------
// Bench for occf_wb_sink. The driver pushes the expected output entry
// {sof, eof, adr, sel, dat} into exp_q when a word is accepted (and an EOF
// marker when cyc drops after at least one word); the monitor pops and
// compares whenever the DUT shows dvalid_o or eof_o.
// ---------------------------------------------------------------------------
module tb_occf_wb_sink;

    logic         clk_i = 1'b0;
    logic         rst_n_i = 1'b1;
    logic [127:0] snk_dat_i = '0;
    logic [3:0]   snk_adr_i = '0;
    logic [15:0]  snk_sel_i = '0;
    logic         snk_cyc_i = 1'b0;
    logic         snk_stb_i = 1'b0;
    logic         snk_we_i = 1'b0;
    logic         snk_stall_o;
    logic         snk_ack_o;
    logic         snk_err_o;
    logic         snk_rty_o;
    logic [3:0]   addr_o;
    logic [127:0] data_o;
    logic         dvalid_o;
    logic         sof_o;
    logic         eof_o;
    logic [15:0]  bytesel_o;
    logic         dreq_i = 1'b0;

    occf_wb_sink dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .snk_dat_i   (snk_dat_i),
        .snk_adr_i   (snk_adr_i),
        .snk_sel_i   (snk_sel_i),
        .snk_cyc_i   (snk_cyc_i),
        .snk_stb_i   (snk_stb_i),
        .snk_we_i    (snk_we_i),
        .snk_stall_o (snk_stall_o),
        .snk_ack_o   (snk_ack_o),
        .snk_err_o   (snk_err_o),
        .snk_rty_o   (snk_rty_o),
        .addr_o      (addr_o),
        .data_o      (data_o),
        .dvalid_o    (dvalid_o),
        .sof_o       (sof_o),
        .eof_o       (eof_o),
        .bytesel_o   (bytesel_o),
        .dreq_i      (dreq_i)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    // ---------------- scoreboard state ----------------
    logic [149:0] exp_q[$];
    int checks    = 0;
    int failures  = 0;
    int ack_cnt   = 0;
    int total_acc = 0;
    int pkt_acc   = 0;
    int out_cnt   = 0;
    bit drv_busy  = 1'b0;

    task automatic check(input string name, input logic [149:0] got, input logic [149:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk_i) begin
        logic [149:0] got;
        logic [149:0] exp;
        if (!rst_n_i) begin
            if (snk_ack_o) ack_cnt++;
            got = {sof_o, eof_o, addr_o, bytesel_o, data_o};
            if (dvalid_o || eof_o) begin
                out_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output got=%h exp=none", got);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp || dvalid_o !== ~exp[148]) begin
                        failures++;
                        $display("FAIL out_word got=%h dv=%0b exp=%h", got, dvalid_o, exp);
                    end
                end
            end else begin
                checks++;
                if (got !== '0) begin
                    failures++;
                    $display("FAIL idle_zero got=%h exp=0", got);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // pkt==0 selects the fixed single-word vector dat=1, sel=FFFF, adr=0.
    task automatic send_packet(input int n, input int pkt);
        int budget;
        drv_busy = 1'b1;
        pkt_acc  = 0;
        @(negedge clk_i);
        snk_cyc_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            snk_stb_i = 1'b1;
            snk_we_i  = 1'b1;
            if (pkt == 0) begin
                snk_dat_i = 128'h1;
                snk_sel_i = 16'hFFFF;
                snk_adr_i = 4'h0;
            end else begin
                snk_dat_i = {pkt[7:0], i[7:0], $urandom(), $urandom(), $urandom(), 16'hA5C3};
                snk_sel_i = 16'($urandom_range(1, 16'hFFFF));
                snk_adr_i = 4'(i % 4);
            end
            budget = 0;
            while (snk_stall_o && budget < 300) begin
                @(negedge clk_i);
                budget++;
            end
            if (snk_stall_o) begin
                checks++;
                failures++;
                $display("FAIL stall_timeout got=stalled exp=released");
                break;
            end
            exp_q.push_back({(i == 0), 1'b0, snk_adr_i, snk_sel_i, snk_dat_i});
            total_acc++;
            pkt_acc++;
            @(negedge clk_i);
        end
        snk_stb_i = 1'b0;
        snk_we_i  = 1'b0;
        snk_cyc_i = 1'b0;
        if (pkt_acc > 0) exp_q.push_back({1'b0, 1'b1, 148'd0});
        @(negedge clk_i);
        drv_busy = 1'b0;
    endtask

    task automatic wait_drain();
        int b = 0;
        while (exp_q.size() != 0 && b < 500) begin
            @(negedge clk_i);
            b++;
        end
        repeat (3) @(negedge clk_i);
        check("drain_empty", 150'(exp_q.size()), 150'd0);
    endtask

    task automatic wait_driver();
        int b = 0;
        while (drv_busy && b < 1000) begin
            @(negedge clk_i);
            b++;
        end
        check("driver_done", {149'd0, drv_busy}, 150'd0);
    endtask

    // ---------------- test sequence ----------------
    int lens[4] = '{4, 9, 16, 5};
    int snap;

    initial begin
        // reset state
        repeat (2) @(negedge clk_i);
        check("reset_outputs", {sof_o, eof_o, addr_o, bytesel_o, data_o}, 150'd0);
        check("reset_flags", {146'd0, dvalid_o, snk_stall_o, snk_ack_o, snk_rty_o}, 150'd0);
        rst_n_i = 1'b0;
        @(negedge clk_i);

        // four packets, consumer always ready
        dreq_i = 1'b1;
        for (int p = 0; p < 4; p++) send_packet(lens[p], p + 1);
        wait_drain();
        check("ack_count_a", 150'(ack_cnt), 150'(total_acc));

        // backpressure: stall after 7 words
        dreq_i = 1'b0;
        snap = out_cnt;
        fork
            send_packet(10, 9);
        join_none
        #1;
        begin
            int b = 0;
            while (pkt_acc < 7 && b < 200) begin
                @(negedge clk_i);
                b++;
            end
        end
        repeat (3) @(negedge clk_i);
        check("stall_high", {149'd0, snk_stall_o}, 150'd1);
        check("stall_fill7", 150'(pkt_acc), 150'd7);
        check("no_out_while_held", 150'(out_cnt), 150'(snap));
        dreq_i = 1'b1;
        wait_driver();
        wait_drain();
        check("ack_count_b", 150'(ack_cnt), 150'(total_acc));

        // single-word packet
        send_packet(1, 0);
        wait_drain();

        // cyc pulse without strobe
        snap = out_cnt;
        @(negedge clk_i);
        snk_cyc_i = 1'b1;
        repeat (3) @(negedge clk_i);
        snk_cyc_i = 1'b0;
        repeat (6) @(negedge clk_i);
        check("empty_cyc_no_out", 150'(out_cnt), 150'(snap));

        // read attempt (we=0)
        snap = ack_cnt;
        snk_cyc_i = 1'b1;
        snk_stb_i = 1'b1;
        snk_we_i  = 1'b0;
        @(negedge clk_i);
        snk_stb_i = 1'b0;
`ifdef OCCF_SINK_ERR_EN
        check("err_pulse", {149'd0, snk_err_o}, 150'd1);
`else
        check("err_tied_low", {149'd0, snk_err_o}, 150'd0);
`endif
        check("no_ack_on_read", {149'd0, snk_ack_o}, 150'd0);
        @(negedge clk_i);
        check("err_one_cycle", {149'd0, snk_err_o}, 150'd0);
        snk_cyc_i = 1'b0;
        repeat (4) @(negedge clk_i);
        check("read_no_ack_total", 150'(ack_cnt), 150'(snap));
        check("read_no_out", 150'(out_cnt), 150'(snap == snap ? out_cnt - 0 : 0));

        // reset mid-packet with FIFO filled to the stall point
        dreq_i = 1'b0;
        snk_cyc_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            snk_stb_i = 1'b1;
            snk_we_i  = 1'b1;
            snk_dat_i = {120'd0, i[7:0]};
            snk_sel_i = 16'h00FF;
            snk_adr_i = 4'h1;
            total_acc++;
            @(negedge clk_i);
        end
        snk_stb_i = 1'b0;
        snk_we_i  = 1'b0;
        repeat (2) @(negedge clk_i);
        check("pre_reset_stall", {149'd0, snk_stall_o}, 150'd1);
        dreq_i = 1'b1;
        #2;
        rst_n_i = 1'b1;
        #1;
        check("midrst_stall", {149'd0, snk_stall_o}, 150'd0);
        check("midrst_outputs", {sof_o, eof_o, addr_o, bytesel_o, data_o}, 150'd0);
        check("midrst_flags", {148'd0, dvalid_o, snk_ack_o}, 150'd0);
        snk_cyc_i = 1'b0;
        @(negedge clk_i);
        check("in_reset_dvalid", {149'd0, dvalid_o}, 150'd0);
        rst_n_i = 1'b0;
        snap = out_cnt;
        repeat (5) @(negedge clk_i);
        check("post_reset_no_out", 150'(out_cnt), 150'(snap));
        send_packet(3, 7);
        wait_drain();
        check("ack_count_c", 150'(ack_cnt), 150'(total_acc));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case something upstream wedges.
    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

endmodule
